axi_lite_initiator: RTL



---
 rtl/axi_lite_initiator_pkg.sv | 25 ++
 rtl/axi_bus.sv | 90 +++++++++
 rtl/axi_lite_initiator.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/axi_lite_initiator_pkg.sv
// Shared types and AXI encodings for the single-outstanding AXI4-Lite initiator.
package axi_lite_initiator_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        WRITE_B = 3'd2,
        READ_AR = 3'd3,
        READ_R  = 3'd4
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_8B    = 3'd3;

    // SLVERR and DECERR both have the upper response bit set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/axi_bus.sv
// Generic AXI4 bus bundle with master and slave views, shared by initiator and peripherals.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [5:0]                aw_atop;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/axi_lite_initiator.sv
// Turns a req/gnt/rvalid memory port into single-beat AXI4-Lite reads and writes,
// one transaction in flight at a time.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | gnt_o follows req_i; request latched on grant
//   WRITE   | AW and W offered, each until its own handshake
//   WRITE_B | waiting for the write response
//   READ_AR | AR offered until accepted
//   READ_R  | waiting for the read data beat
module axi_lite_initiator
    import axi_lite_initiator_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
    input  logic [63:0]               wdata_i,
    input  logic [7:0]                be_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [63:0]               rdata_o,
    output logic                      err_o,
    AXI_BUS.Master                    master
);

    if (AXI_DATA_WIDTH != 64) begin : g_bad_data_width
        $fatal(1, "axi_lite_initiator: AXI_DATA_WIDTH must be 64");
    end

    state_e                    state_q, state_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [63:0]               wdata_q, wdata_d;
    logic [7:0]                strb_q, strb_d;
    logic [63:0]               rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      rvalid_q, rvalid_d;

    logic aw_valid, w_valid, b_ready, ar_valid, r_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            rvalid_q  <= rvalid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        rvalid_d  = 1'b0;
        gnt_o     = 1'b0;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        b_ready   = 1'b0;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;

        unique case (state_q)
            IDLE: begin
                gnt_o = req_i;
                if (req_i) begin
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    strb_d  = be_i;
                    state_d = we_i ? WRITE : READ_AR;
                end
            end
            WRITE: begin
                // Valids come only from the done flags, never from ready.
                aw_valid = !aw_done_q;
                w_valid  = !w_done_q;
                if (aw_valid && master.aw_ready) aw_done_d = 1'b1;
                if (w_valid && master.w_ready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WRITE_B;
                end
            end
            WRITE_B: begin
                b_ready = 1'b1;
                if (master.b_valid) begin
                    err_d    = resp_is_err(master.b_resp);
                    rvalid_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            READ_AR: begin
                ar_valid = 1'b1;
                if (master.ar_ready) state_d = READ_R;
            end
            READ_R: begin
                r_ready = 1'b1;
                if (master.r_valid) begin
                    rdata_d  = master.r_data;
                    err_d    = resp_is_err(master.r_resp);
                    rvalid_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

    assign master.aw_id     = {AXI_ID_WIDTH{1'b0}};
    assign master.aw_addr   = addr_q;
    assign master.aw_len    = 8'd0;
    assign master.aw_size   = SIZE_8B;
    assign master.aw_burst  = BURST_INCR;
    assign master.aw_lock   = 1'b0;
    assign master.aw_cache  = 4'd0;
    assign master.aw_prot   = 3'd0;
    assign master.aw_qos    = 4'd0;
    assign master.aw_region = 4'd0;
    assign master.aw_atop   = 6'd0;
    assign master.aw_user   = '0;
    assign master.aw_valid  = aw_valid;

    assign master.w_data  = wdata_q;
    assign master.w_strb  = strb_q;
    assign master.w_last  = 1'b1;
    assign master.w_user  = '0;
    assign master.w_valid = w_valid;

    assign master.b_ready = b_ready;

    assign master.ar_id     = {AXI_ID_WIDTH{1'b0}};
    assign master.ar_addr   = addr_q;
    assign master.ar_len    = 8'd0;
    assign master.ar_size   = SIZE_8B;
    assign master.ar_burst  = BURST_INCR;
    assign master.ar_lock   = 1'b0;
    assign master.ar_cache  = 4'd0;
    assign master.ar_prot   = 3'd0;
    assign master.ar_qos    = 4'd0;
    assign master.ar_region = 4'd0;
    assign master.ar_user   = '0;
    assign master.ar_valid  = ar_valid;

    assign master.r_ready = r_ready;

endmodule
